// File: rtl/script_step_sequencer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : script_step_sequencer_pkg
//  Description : Shared constants for the script step sequencer. Covers byte
//                channels, opcodes, station targets, feedback bit positions
//                and the state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package script_step_sequencer_pkg;

  // Low two bits of every script byte select the channel.
  localparam logic [1:0] CH_TARGET  = 2'b11;
  localparam logic [1:0] CH_OPERATE = 2'b10;

  // Operation payloads, used with CH_OPERATE.
  localparam logic [5:0] OP_GET   = 6'd1;
  localparam logic [5:0] OP_THROW = 6'd2;
  localparam logic [5:0] OP_MOVE  = 6'd3;

  // Target payloads, used with CH_TARGET.
  localparam logic [5:0] TABLE_1   = 6'd1;
  localparam logic [5:0] TABLE_2   = 6'd2;
  localparam logic [5:0] TABLE_3   = 6'd3;
  localparam logic [5:0] TABLE_4   = 6'd4;
  localparam logic [5:0] TRASH_BIN = 6'd5;

  // Bit positions inside the receiver feedback byte.
  localparam int FB_HAS_ITEM      = 0;
  localparam int FB_IS_PROCESSING = 1;

  localparam logic [7:0] SCRIPT_END = 8'h00;

  // State encoding.
  localparam logic [3:0] ST_IDLE         = 4'd0;
  localparam logic [3:0] ST_FETCH        = 4'd1;
  localparam logic [3:0] ST_ROMWAIT      = 4'd2;
  localparam logic [3:0] ST_ISSUE        = 4'd3;
  localparam logic [3:0] ST_WAIT_FB      = 4'd4;
  localparam logic [3:0] ST_POLL         = 4'd5;
  localparam logic [3:0] ST_FIX_TRASH    = 4'd6;
  localparam logic [3:0] ST_FIX_THROW    = 4'd7;
  localparam logic [3:0] ST_FIX_RETARGET = 4'd8;
  localparam logic [3:0] ST_DONE         = 4'd9;
  localparam logic [3:0] ST_ERROR        = 4'd10;

  typedef enum logic [3:0] {
    S_IDLE         = ST_IDLE,
    S_FETCH        = ST_FETCH,
    S_ROMWAIT      = ST_ROMWAIT,
    S_ISSUE        = ST_ISSUE,
    S_WAIT_FB      = ST_WAIT_FB,
    S_POLL         = ST_POLL,
    S_FIX_TRASH    = ST_FIX_TRASH,
    S_FIX_THROW    = ST_FIX_THROW,
    S_FIX_RETARGET = ST_FIX_RETARGET,
    S_DONE         = ST_DONE,
    S_ERROR        = ST_ERROR
  } state_e;

  // Tables and the trash bin accept thrown items; anything else (a machine)
  // needs the trash-and-retarget recovery.
  function automatic logic is_drop_target(input logic [5:0] t);
    return (t == TABLE_1) || (t == TABLE_2) || (t == TABLE_3) ||
           (t == TABLE_4) || (t == TRASH_BIN);
  endfunction

endpackage
`default_nettype wire

// File: rtl/script_step_sequencer_timer.sv
`default_nettype none
// ============================================================================
//  Module      : seq_cycle_timer
//  Description : Up-counter with synchronous clear. expired_o is high while
//                the count equals limit_i. The count holds once it is there.
//  Revision    : 1.0 - initial release
// ============================================================================
module seq_cycle_timer #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic             en_i,
  input  logic [WIDTH-1:0] limit_i,
  output logic             expired_o
);

  logic [WIDTH-1:0] cnt_q;

  assign expired_o = (cnt_q == limit_i);

  // Clear on load, otherwise count up while enabled until the limit is reached.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= '0;
    end else if (en_i && !expired_o) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/script_step_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : script_step_sequencer
//  Description : Plays a script ROM out over the UART sender, one byte per
//                step. Each step is checked against the receiver feedback.
//                Recovery options are poll-and-retry for a busy machine and
//                trash-and-retarget for a rejected throw.
//  Revision    : 1.0 - initial release
// ============================================================================
module script_step_sequencer
  import script_step_sequencer_pkg::*;
#(
  parameter int ADDR_W      = 8,
  parameter int POLL_CYCLES = 1000,
  parameter int MAX_RETRY   = 8,
  parameter int FB_TIMEOUT  = 50000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_i,
  output logic [ADDR_W-1:0] rom_addr_o,
  input  logic [7:0]        rom_data_i,
  output logic [7:0]        tx_o,
  output logic              tx_valid_o,
  input  logic              tx_ready_i,
  input  logic [7:0]        feedback_i,
  input  logic              feedback_valid_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              error_o,
  output logic [7:0]        fix_count_o
);

  localparam int TMR_MAX = (POLL_CYCLES > FB_TIMEOUT) ? POLL_CYCLES : FB_TIMEOUT;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);
  localparam int RETRY_W = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

  state_e             state_q;
  logic [ADDR_W-1:0]  pc_q;
  logic [7:0]         instr_q;
  logic [7:0]         tx_q;
  logic               tx_valid_q;
  logic [5:0]         last_target_q;
  logic [RETRY_W-1:0] retry_q;
  logic [7:0]         fix_count_q;
  logic               busy_q;
  logic               done_q;
  logic               error_q;
  logic               fix_wait_q;   // fix state: 0 = sending byte, 1 = awaiting feedback

  logic               handshake;
  logic               in_fix;
  logic               waiting_fb;
  logic               fb_accept;
  logic               counting;
  logic               tmr_load;
  logic [TMR_W-1:0]   tmr_limit;
  logic               tmr_expired;
  logic               need_trash_fix;
  logic               need_poll;

  assign handshake  = tx_valid_q && tx_ready_i;
  assign in_fix     = (state_q == S_FIX_TRASH) || (state_q == S_FIX_THROW) ||
                      (state_q == S_FIX_RETARGET);
  // Feedback is only looked at after the byte has left. The handshake cycle
  // itself is never a waiting cycle.
  assign waiting_fb = (state_q == S_WAIT_FB) || (in_fix && fix_wait_q);
  assign fb_accept  = waiting_fb && feedback_valid_i;
  assign counting   = waiting_fb || (state_q == S_POLL);
  // Restart the timer when idle. Also restart it on accepted feedback, so that
  // POLL begins from zero.
  assign tmr_load   = !counting || fb_accept;
  assign tmr_limit  = (state_q == S_POLL) ? TMR_W'(POLL_CYCLES - 1)
                                          : TMR_W'(FB_TIMEOUT - 1);

  assign need_trash_fix = (instr_q == {OP_THROW, CH_OPERATE}) &&
                          feedback_i[FB_HAS_ITEM] &&
                          !is_drop_target(last_target_q);
  assign need_poll      = (instr_q == {OP_GET, CH_OPERATE}) &&
                          feedback_i[FB_IS_PROCESSING];

  seq_cycle_timer #(
    .WIDTH (TMR_W)
  ) u_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .load_i    (tmr_load),
    .en_i      (counting),
    .limit_i   (tmr_limit),
    .expired_o (tmr_expired)
  );

  // Step sequencer: fetch, send, check feedback, and recover where needed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      pc_q          <= '0;
      instr_q       <= '0;
      tx_q          <= '0;
      tx_valid_q    <= 1'b0;
      last_target_q <= '0;
      retry_q       <= '0;
      fix_count_q   <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      error_q       <= 1'b0;
      fix_wait_q    <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE, S_ERROR: begin
          if (start_i) begin
            pc_q        <= '0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            fix_count_q <= '0;
            busy_q      <= 1'b1;
            state_q     <= S_FETCH;
          end
        end

        // rom_addr_o follows pc_q, so the ROM samples the address during this cycle.
        S_FETCH: state_q <= S_ROMWAIT;

        S_ROMWAIT: begin
          instr_q <= rom_data_i;
          if (rom_data_i == SCRIPT_END) begin
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= S_DONE;
          end else begin
            tx_q       <= rom_data_i;
            tx_valid_q <= 1'b1;
            retry_q    <= '0;
            state_q    <= S_ISSUE;
          end
        end

        S_ISSUE: begin
          if (handshake) begin
            tx_valid_q <= 1'b0;
            if (instr_q[1:0] == CH_TARGET) begin
              last_target_q <= instr_q[7:2];
            end
            state_q <= S_WAIT_FB;
          end
        end

        S_WAIT_FB: begin
          if (feedback_valid_i) begin
            if (need_trash_fix) begin
              tx_q       <= {TRASH_BIN, CH_TARGET};
              tx_valid_q <= 1'b1;
              fix_wait_q <= 1'b0;
              state_q    <= S_FIX_TRASH;
            end else if (need_poll) begin
              state_q <= S_POLL;
            end else begin
              pc_q    <= pc_q + 1'b1;
              state_q <= S_FETCH;
            end
          end else if (tmr_expired) begin
            error_q <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= S_ERROR;
          end
        end

        S_POLL: begin
          if (tmr_expired) begin
            if (retry_q == RETRY_W'(MAX_RETRY)) begin
              error_q <= 1'b1;
              busy_q  <= 1'b0;
              state_q <= S_ERROR;
            end else begin
              retry_q    <= retry_q + 1'b1;
              tx_q       <= instr_q;
              tx_valid_q <= 1'b1;
              state_q    <= S_ISSUE;
            end
          end
        end

        S_FIX_TRASH, S_FIX_THROW, S_FIX_RETARGET: begin
          if (!fix_wait_q) begin
            if (handshake) begin
              tx_valid_q <= 1'b0;
              fix_wait_q <= 1'b1;
            end
          end else if (feedback_valid_i) begin
            fix_wait_q <= 1'b0;
            if (state_q == S_FIX_TRASH) begin
              tx_q       <= {OP_THROW, CH_OPERATE};
              tx_valid_q <= 1'b1;
              state_q    <= S_FIX_THROW;
            end else if (state_q == S_FIX_THROW) begin
              tx_q       <= {last_target_q, CH_TARGET};
              tx_valid_q <= 1'b1;
              state_q    <= S_FIX_RETARGET;
            end else begin
              if (fix_count_q != 8'hFF) begin
                fix_count_q <= fix_count_q + 1'b1;
              end
              pc_q    <= pc_q + 1'b1;
              state_q <= S_FETCH;
            end
          end else if (tmr_expired) begin
            fix_wait_q <= 1'b0;
            error_q    <= 1'b1;
            busy_q     <= 1'b0;
            state_q    <= S_ERROR;
          end
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign rom_addr_o  = pc_q;
  assign tx_o        = tx_q;
  assign tx_valid_o  = tx_valid_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign error_o     = error_q;
  assign fix_count_o = fix_count_q;

endmodule
`default_nettype wire

// File: tb/tb_script_step_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_script_step_sequencer
//  Description : Directed vector bench for script_step_sequencer. It includes
//                a ROM model and a sender/receiver responder.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_script_step_sequencer;

  localparam int POLL  = 20;
  localparam int RETRY = 3;
  localparam int TMO   = 40;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] rom_addr;
  logic [7:0] rom_data = 8'h00;
  logic [7:0] tx;
  logic       tx_valid;
  logic       tx_ready = 1'b1;
  logic [7:0] fb = 8'h00;
  logic       fb_valid = 1'b0;
  logic       busy, done, error;
  logic [7:0] fix_count;

  always #5 clk = ~clk;

  script_step_sequencer #(
    .ADDR_W      (8),
    .POLL_CYCLES (POLL),
    .MAX_RETRY   (RETRY),
    .FB_TIMEOUT  (TMO)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .start_i          (start),
    .rom_addr_o       (rom_addr),
    .rom_data_i       (rom_data),
    .tx_o             (tx),
    .tx_valid_o       (tx_valid),
    .tx_ready_i       (tx_ready),
    .feedback_i       (fb),
    .feedback_valid_i (fb_valid),
    .busy_o           (busy),
    .done_o           (done),
    .error_o          (error),
    .fix_count_o      (fix_count)
  );

  // Synchronous script ROM: data follows the address by one cycle.
  logic [7:0] rom [256];
  always @(posedge clk) rom_data <= rom[rom_addr];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Responder state.
  bit          fb_en = 1'b1;
  int          cd = 0;
  logic [95:0] fb_bytes = '0;
  int          fb_n = 0;
  int          fb_idx = 0;
  logic [7:0]  tx_log [64];
  int          tx_time [64];
  int          n_log = 0;
  int          stall_cnt = 0;
  bit          stalling = 1'b0;
  logic [7:0]  st_tx [8];
  logic        st_v [8];
  int          st_n = 0;

  // Sender/receiver model. It runs on the falling edge, logs accepted bytes
  // and returns one feedback pulse in the cycle after each handshake.
  initial begin : responder
    forever begin
      @(negedge clk);
      fb_valid = 1'b0;
      if (cd > 0) begin
        cd--;
        if (cd == 0 && fb_en) begin
          fb = 8'h00;
          if (fb_idx < fb_n) fb = fb_bytes[95-8*fb_idx -: 8];
          fb_valid = 1'b1;
          fb_idx++;
        end
      end
      if (stall_cnt > 0 && (stalling || tx_valid)) begin
        stalling = 1'b1;
        tx_ready = 1'b0;
        if (st_n < 8) begin
          st_tx[st_n] = tx;
          st_v[st_n]  = tx_valid;
          st_n++;
        end
        stall_cnt--;
      end else begin
        stalling = 1'b0;
        tx_ready = 1'b1;
      end
      if (tx_valid && tx_ready && rst_n) begin
        if (n_log < 64) begin
          tx_log[n_log]  = tx;
          tx_time[n_log] = cyc;
          n_log++;
        end
        cd = 1;
      end
    end
  end

  typedef struct {
    string       name;
    logic [95:0] prog;   // bytes left-justified, byte 0 in the top bits
    logic [95:0] fbs;
    int          n_fb;
    logic [95:0] txs;
    int          n_tx;
    bit          done;
    bit          err;
    logic [7:0]  fix;
  } vec_t;

  vec_t vecs [16];
  int   n_vecs = 0;
  int   n_vec = 0;
  int   n_err = 0;

  function automatic logic [95:0] lj(input int n, input logic [95:0] v);
    return v << (8 * (12 - n));
  endfunction

  task automatic add(input string nm, input logic [95:0] p, input logic [95:0] f,
                     input int nf, input logic [95:0] t, input int nt,
                     input bit d, input bit e, input logic [7:0] fx);
    vecs[n_vecs].name = nm;
    vecs[n_vecs].prog = p;
    vecs[n_vecs].fbs  = f;
    vecs[n_vecs].n_fb = nf;
    vecs[n_vecs].txs  = t;
    vecs[n_vecs].n_tx = nt;
    vecs[n_vecs].done = d;
    vecs[n_vecs].err  = e;
    vecs[n_vecs].fix  = fx;
    n_vecs++;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic load_run(input logic [95:0] p, input logic [95:0] f, input int nf);
    for (int i = 0; i < 256; i++) rom[i] = 8'h00;
    for (int i = 0; i < 12; i++) rom[i] = p[95-8*i -: 8];
    fb_bytes = f;
    fb_n     = nf;
    fb_idx   = 0;
    n_log    = 0;
    cd       = 0;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic wait_end(input string nm, input int limit);
    int t;
    t = 0;
    while (!(done || error) && t < limit) begin
      @(negedge clk);
      t++;
    end
    if (!(done || error)) chk({nm, ".finish"}, 32'(done | error), 32'd1);
  endtask

  task automatic run_vec(input int k);
    load_run(vecs[k].prog, vecs[k].fbs, vecs[k].n_fb);
    wait_end(vecs[k].name, 2000);
    chk({vecs[k].name, ".tx_count"}, 32'(n_log), 32'(vecs[k].n_tx));
    for (int i = 0; i < vecs[k].n_tx; i++)
      chk($sformatf("%s.tx[%0d]", vecs[k].name, i), 32'(tx_log[i]),
          32'(vecs[k].txs[95-8*i -: 8]));
    chk({vecs[k].name, ".done"},  32'(done),      32'(vecs[k].done));
    chk({vecs[k].name, ".error"}, 32'(error),     32'(vecs[k].err));
    chk({vecs[k].name, ".fix"},   32'(fix_count), 32'(vecs[k].fix));
    chk({vecs[k].name, ".busy"},  32'(busy),      32'd0);
  endtask

  initial begin : main
    int t;
    // name, rom, feedback bytes, n, expected tx bytes, n, done, error, fix_count
    add("basic",       lj(3, 96'h070600), '0, 0, lj(2, 96'h0706), 2, 1, 0, 8'd0);
    add("get_poll",    lj(2, 96'h0600), lj(3, 96'h020200), 3, lj(3, 96'h060606), 3, 1, 0, 8'd0);
    add("throw_fix",   lj(3, 96'h270A00), lj(2, 96'h0001), 2,
                       lj(5, 96'h270A170A27), 5, 1, 0, 8'd1);
    add("throw_table4", lj(3, 96'h130A00), lj(2, 96'h0001), 2, lj(2, 96'h130A), 2, 1, 0, 8'd0);
    add("throw_trash", lj(3, 96'h170A00), lj(2, 96'h0001), 2, lj(2, 96'h170A), 2, 1, 0, 8'd0);
    add("throw_t6",    lj(3, 96'h1B0A00), lj(2, 96'h0001), 2,
                       lj(5, 96'h1B0A170A1B), 5, 1, 0, 8'd1);
    add("get_stuck",   lj(2, 96'h0600), {12{8'h02}}, 12, lj(4, 96'h06060606), 4, 0, 1, 8'd0);
    add("get_item",    lj(2, 96'h0600), lj(1, 96'h01), 1, lj(1, 96'h06), 1, 1, 0, 8'd0);
    add("move",        lj(2, 96'h0E00), lj(1, 96'h03), 1, lj(1, 96'h0E), 1, 1, 0, 8'd0);
    add("throw_busy",  lj(3, 96'h270A00), lj(2, 96'h0002), 2, lj(2, 96'h270A), 2, 1, 0, 8'd0);
    add("double_fix",  lj(4, 96'h270A0A00), lj(6, 96'h000100000001), 6,
                       lj(9, 96'h270A170A270A170A27), 9, 1, 0, 8'd2);
    add("end_only",    lj(1, 96'h00), '0, 0, '0, 0, 1, 0, 8'd0);

    for (int i = 0; i < 256; i++) rom[i] = 8'h00;

    // Reset values
    repeat (3) @(negedge clk);
    #1;
    chk("rst.rom_addr", 32'(rom_addr),  32'd0);
    chk("rst.tx",       32'(tx),        32'd0);
    chk("rst.tx_valid", 32'(tx_valid),  32'd0);
    chk("rst.busy",     32'(busy),      32'd0);
    chk("rst.done",     32'(done),      32'd0);
    chk("rst.error",    32'(error),     32'd0);
    chk("rst.fix",      32'(fix_count), 32'd0);
    @(negedge clk) rst_n = 1'b1;

    for (int k = 0; k < n_vecs; k++) begin
      run_vec(k);
      // Re-issue spacing: ISSUE, WAIT_FB, POLL x POLL, then ISSUE again
      if (vecs[k].name == "get_poll") begin
        chk("get_poll.gap0", 32'(tx_time[1] - tx_time[0]), 32'(POLL + 2));
        chk("get_poll.gap1", 32'(tx_time[2] - tx_time[1]), 32'(POLL + 2));
      end
    end

    // Back-pressure for 5 cycles, then silence until the feedback timeout
    stall_cnt = 5;
    st_n      = 0;
    fb_en     = 1'b0;
    load_run(lj(2, 96'h0700), '0, 0);
    wait_end("stall", 500);
    chk("stall.count", 32'(st_n), 32'd5);
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("stall.valid[%0d]", i), 32'(st_v[i]), 32'd1);
      chk($sformatf("stall.tx[%0d]", i), 32'(st_tx[i]), 32'h07);
    end
    chk("stall.tx_count", 32'(n_log), 32'd1);
    chk("timeout.error", 32'(error), 32'd1);
    chk("timeout.busy",  32'(busy),  32'd0);
    chk("timeout.done",  32'(done),  32'd0);
    chk("timeout.latency", 32'(cyc - tx_time[0]), 32'(TMO + 1));
    fb_en = 1'b1;

    // Asynchronous reset while the recovery THROW is being offered
    load_run(lj(3, 96'h270A00), lj(2, 96'h0001), 2);
    t = 0;
    while (!(n_log >= 3 && tx_valid && tx == 8'h0A) && t < 500) begin
      @(negedge clk);
      t++;
    end
    chk("fixrst.reached", 32'(n_log >= 3 && tx_valid && tx == 8'h0A), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("fixrst.tx_valid", 32'(tx_valid),  32'd0);
    chk("fixrst.tx",       32'(tx),        32'd0);
    chk("fixrst.busy",     32'(busy),      32'd0);
    chk("fixrst.rom_addr", 32'(rom_addr),  32'd0);
    chk("fixrst.done",     32'(done),      32'd0);
    chk("fixrst.error",    32'(error),     32'd0);
    chk("fixrst.fix",      32'(fix_count), 32'd0);
    @(negedge clk) rst_n = 1'b1;
    run_vec(0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/script_step_sequencer.md
Name: script_step_sequencer

Overview:
- Plays a stored cooking script over the UART sender, one byte per step, and checks each step against the receiver feedback byte.
- Applies on-the-fly recovery on failure:
  - poll-and-retry while a machine is still processing;
  - trash-and-retarget when a throw is rejected.
- Sits between the script ROM, the UART sender (tx handshake) and the UART receiver (feedback). It is a sequential replacement for combinational per-byte fixing.

Parameters:
- ADDR_W, 8, script ROM address width.
- POLL_CYCLES, 1000, idle cycles between GET re-issues while the machine is processing.
- MAX_RETRY, 8, maximum GET re-issues per step before the sequencer enters ERROR.
- FB_TIMEOUT, 50000, cycles to wait for feedback_valid after a tx handshake before the sequencer enters ERROR.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  1-cycle pulse; starts the script from address 0 (ignored unless IDLE/DONE/ERROR)
- rom_addr  out  ADDR_W  script ROM address
- rom_data  in  8  script byte; valid exactly 1 cycle after rom_addr
- tx  out  8  byte to sender: {payload[5:0], channel[1:0]}
- tx_valid  out  1  tx is valid; held with tx stable until tx_ready
- tx_ready  in  1  sender accepts tx when tx_valid&&tx_ready
- feedback  in  8  receiver status byte
- feedback_valid  in  1  1-cycle pulse: new feedback after a command
- busy  out  1  script is running (not IDLE/DONE/ERROR)
- done  out  1  level; END byte reached
- error  out  1  level; timeout or retry exhaustion
- fix_count  out  8  recovery sequences executed this run (saturating at 255)

Behaviour:
- Reset values: rom_addr=0, tx=0, tx_valid=0, busy=0, done=0, error=0, fix_count=0, pc=0, last_target=0, state=IDLE. Reset mid-run aborts immediately and drops tx_valid in the same instant (async).
- Byte decode:
  - channel==CH_TARGET (2'b11): target select; payload is recorded into last_target on handshake.
  - channel==CH_OPERATE (2'b10): operation.
  - 8'h00 = END.
- States and transitions:
  - IDLE: on start → FETCH. On start: pc=0, done=0, error=0, fix_count=0.
  - FETCH: rom_addr=pc → ROMWAIT.
  - ROMWAIT: latch instr=rom_data. If END → DONE, else → ISSUE with tx=instr, retry=0.
  - ISSUE: tx_valid=1. On handshake: tx_valid=0 → WAIT_FB, timer=0.
  - WAIT_FB: on feedback_valid evaluate in this priority order (first match wins):
    1. instr=={OP_THROW,CH_OPERATE}, feedback[FB_HAS_ITEM]=1, and last_target is not TABLE_1..4 and not TRASH_BIN → FIX_TRASH.
    2. instr=={OP_GET,CH_OPERATE} and feedback[FB_IS_PROCESSING]=1 → POLL.
    3. Otherwise the step is complete: pc=pc+1 → FETCH.
  - WAIT_FB timeout: timer reaching FB_TIMEOUT-1 without feedback_valid → ERROR.
  - POLL: count POLL_CYCLES cycles. Then, if retry==MAX_RETRY → ERROR; else retry+1, tx=instr → ISSUE.
  - FIX_TRASH: send {TRASH_BIN,CH_TARGET}.
  - FIX_THROW: send {OP_THROW,CH_OPERATE}.
  - FIX_RETARGET: send {last_target,CH_TARGET}. Then fix_count+1, pc+1 → FETCH.
  - Fix-state handshakes: each fix byte uses the same tx_valid/tx_ready handshake, and the sequencer waits for its feedback_valid, with the same timeout, before advancing. last_target is not overwritten during the fix sequence.
  - DONE / ERROR: hold done/error high; start → restart as in IDLE.
- Handshake and timing:
  - tx must not change while tx_valid=1 && !tx_ready.
  - A feedback_valid arriving outside WAIT_FB (or the fix-feedback waits) is ignored.
  - feedback_valid in the same cycle as the handshake is ignored; feedback is counted from the next cycle.
- Widths and wrap: pc wraps at 2^ADDR_W with no END → continues from 0 (script author's responsibility). Timers are wide enough for the parameters, with no overflow.
- start while busy is ignored.
- Minimum latency per clean step: FETCH+ROMWAIT+ISSUE(1 if tx_ready high)+feedback = 4 cycles.

Decomposition:
- Shared package gains:
  - CH_TARGET, CH_OPERATE;
  - OP_GET, OP_THROW, OP_MOVE;
  - TRASH_BIN, TABLE_1..4;
  - FB_HAS_ITEM, FB_IS_PROCESSING bit indices;
  - SCRIPT_END=8'h00;
  - state encoding localparams.
- One sub-module, seq_cycle_timer (load/count/expire), shared by the POLL and WAIT_FB timeout paths.

Test Plan:
- ROM {TABLE_1,11},{GET,10},END; tx_ready=1; feedback=0 each step → exactly 2 tx bytes in order, done=1, fix_count=0, error=0.
- GET step; IS_PROCESSING=1 for the first 2 feedbacks, then 0 → GET sent 3 times, gaps ≥POLL_CYCLES, then pc advances.
- Machine target 6'd9 selected, THROW step, feedback HAS_ITEM=1 → tx sequence {TRASH,11},{THROW,10},{6'd9,11}; fix_count=1.
- GET with IS_PROCESSING stuck at 1 → MAX_RETRY+1 GETs total, then error=1, busy=0.
- tx_ready held low 5 cycles → tx stable and tx_valid high throughout; no feedback for FB_TIMEOUT cycles → error=1.
- rst_n low during FIX_THROW → all outputs at reset values immediately; start afterwards replays from address 0.
